wide_add_seq_v: RTL and testbench

//   Multi-cycle wide adder sequencer. Splits NUM_WORDS*DATA_WIDTH-bit operands into

---
 rtl/wide_add_seq_v.sv | 172 +++++++++++++++++
 tb/tb_wide_add_seq_v.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq_v.sv
// wide_add_seq_v
//   Multi-cycle wide adder sequencer. A full-width operand pair is accepted
//   through a valid/ready handshake. It is then presented LSW-first, one
//   DATA_WIDTH-bit word per cycle, to an external combinational adder.
//   Each word's sum is captured, and its carry is chained into the next word.
//   The assembled result is returned through a second valid/ready handshake.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (op_a, op_b, cin)
//   add_a/add_b/add_ci  word operands and carry driven to the external adder
//   add_sum/add_cout    same-cycle sum and carry returned by the external adder
//   out_valid/out_ready result handshake (result, cout)
//   busy                high while an operation is in flight or awaiting pickup
module wide_add_seq_v #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] op_a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] op_b,
  input  logic                            cin,
  output logic [DATA_WIDTH-1:0]           add_a,
  output logic [DATA_WIDTH-1:0]           add_b,
  output logic                            add_ci,
  input  logic [DATA_WIDTH-1:0]           add_sum,
  input  logic                            add_cout,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] result,
  output logic                            cout,
  output logic                            busy
);

  localparam int W     = DATA_WIDTH * NUM_WORDS;
  // One extra bit so the index never wraps, even when NUM_WORDS is a power of two.
  localparam int IDX_W = $clog2(NUM_WORDS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IDX_W-1:0]        idx_r;
  logic                    last_s;
  // Operand words not yet presented to the adder; the bottom word is the next one.
  logic [W-1:0]            a_sh_r;
  logic [W-1:0]            b_sh_r;
  logic [DATA_WIDTH-1:0]   add_a_r;
  logic [DATA_WIDTH-1:0]   add_b_r;
  // add_ci_r doubles as the inter-word carry register while in RUN.
  logic                    add_ci_r;
  logic [W-1:0]            result_r;
  logic                    cout_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    busy_r;

  assign last_s    = (idx_r == IDX_W'(NUM_WORDS - 1));

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign add_ci    = add_ci_r;
  assign result    = result_r;
  assign cout      = cout_r;

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register, handshake flags and datapath registers.
  // The flags are computed from the next state so that they are flop outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      idx_r       <= '0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      add_a_r     <= '0;
      add_b_r     <= '0;
      add_ci_r    <= 1'b0;
      result_r    <= '0;
      cout_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            // Word 0 goes straight to the adder outputs; the rest wait in the shifters.
            add_a_r  <= op_a[DATA_WIDTH-1:0];
            add_b_r  <= op_b[DATA_WIDTH-1:0];
            add_ci_r <= cin;
            a_sh_r   <= op_a >> DATA_WIDTH;
            b_sh_r   <= op_b >> DATA_WIDTH;
            idx_r    <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
          end
        end
        RUN: begin
          for (int w = 0; w < NUM_WORDS; w++) begin
            if (idx_r == IDX_W'(w)) begin
              result_r[w*DATA_WIDTH +: DATA_WIDTH] <= add_sum;
            end
          end
          idx_r  <= idx_r + IDX_W'(1);
          a_sh_r <= a_sh_r >> DATA_WIDTH;
          b_sh_r <= b_sh_r >> DATA_WIDTH;
          if (last_s) begin
            // Adder inputs return to zero once the top word is captured.
            add_a_r  <= '0;
            add_b_r  <= '0;
            add_ci_r <= 1'b0;
            cout_r   <= add_cout;
          end else begin
            add_a_r  <= a_sh_r[DATA_WIDTH-1:0];
            add_b_r  <= b_sh_r[DATA_WIDTH-1:0];
            add_ci_r <= add_cout;
          end
        end
        DONE: begin
          // result and cout hold until the consumer takes them.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq_v.sv
module tb_wide_add_seq_v;

  localparam int DW = 8;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          cin;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic          add_ci;
  logic [DW-1:0] add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cout;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  wide_add_seq_v #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .busy(busy)
  );

  // External combinational word adder
  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_ci};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present an operand pair, wait for acceptance, then wait for out_valid.
  // Leaves the DUT in DONE with the result still pending.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] r, output logic co, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    r = '0;
    co = 1'b0;
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: out_valid=%b required 1", out_valid);
      return;
    end
    r = result;
    co = cout;
    ok = 1'b1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, busy, cout, add_ci} !== 5'b10000 || result !== '0 ||
        add_a !== '0 || add_b !== '0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b ov=%b busy=%b cout=%b ci=%b res=%h a=%h b=%h required rdy=1 rest 0",
               in_ready, out_valid, busy, cout, add_ci, result, add_a, add_b);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W-1:0] er [4];
    logic         ec [4];
    logic [W-1:0] r;
    logic         co;
    int           lat;
    bit           ok;
    va[0] = 32'h0000_00FF; vb[0] = 32'h0000_0001; vc[0] = 1'b0; er[0] = 32'h0000_0100; ec[0] = 1'b0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vc[1] = 1'b1; er[1] = 32'h0000_0000; ec[1] = 1'b1;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vc[2] = 1'b0; er[2] = 32'h0000_0000; ec[2] = 1'b1;
    va[3] = 32'h1234_5678; vb[3] = 32'h1111_1111; vc[3] = 1'b0; er[3] = 32'h2345_6789; ec[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], r, co, lat, ok);
      if (ok) begin
        n_vec++;
        if (r !== er[i] || co !== ec[i]) begin
          n_err++;
          $display("FAIL directed_%0d: result=%h cout=%b required result=%h cout=%b", i, r, co, er[i], ec[i]);
        end
        n_vec++;
        if (lat != NW) begin
          n_err++;
          $display("FAIL latency_%0d: %0d cycles required %0d", i, lat, NW);
        end
        n_vec++;
        if (add_a !== '0 || add_b !== '0 || add_ci !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL done_outputs_%0d: a=%h b=%h ci=%b busy=%b required 0 0 0 1", i, add_a, add_b, add_ci, busy);
        end
      end
      release_out();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL release_%0d: ov=%b rdy=%b busy=%b required 0 1 0", i, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r;
    logic         co;
    int           lat;
    bit           ok;
    run_op(32'hDEAD_BEEF, 32'h3000_0001, 1'b1, r, co, lat, ok);
    n_vec++;
    if (r !== 32'h0EAD_BEF1 || co !== 1'b1) begin
      n_err++;
      $display("FAIL bp_result: result=%h cout=%b required 0ead_bef1 1", r, co);
    end
    op_a = 32'h1111_1111; op_b = 32'h2222_2222; cin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (result !== r || cout !== co || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold_%0d: result=%h cout=%b rdy=%b ov=%b required %h %b 0 1",
                 k, result, cout, in_ready, out_valid, r, co);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: ov=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r;
    logic         co;
    int           lat;
    bit           ok;
    int           pulses;
    op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== '0 || add_a !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: ov=%b busy=%b rdy=%b result=%h add_a=%h required 0 0 1 0 0",
               out_valid, busy, in_ready, result, add_a);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL aborted_pulse: %0d out_valid cycles required 0", pulses);
    end
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, r, co, lat, ok);
    if (ok) begin
      n_vec++;
      if (r !== 32'h0000_0100 || co !== 1'b0 || lat != NW) begin
        n_err++;
        $display("FAIL post_reset_op: result=%h cout=%b lat=%0d required 00000100 0 %0d", r, co, lat, NW);
      end
    end
    release_out();
  endtask

  task automatic test_random();
    logic [W:0] exp_q [$];
    logic [W:0] e;
    int sent;
    int got;
    int cyc;
    bit acc;
    sent = 0; got = 0; cyc = 0;
    op_a = $urandom; op_b = $urandom; cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    while (got < 2000 && cyc < 60000) begin
      acc = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: result=%h cout=%b with nothing outstanding", result, cout);
        end else begin
          e = exp_q.pop_front();
          if ({cout, result} !== e) begin
            n_err++;
            $display("FAIL rand_%0d: cout=%b result=%h required cout=%b result=%h", got, cout, result, e[W], e[W-1:0]);
          end
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin});
        sent++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        op_a = $urandom; op_b = $urandom; cin = 1'($urandom_range(0, 1));
        in_valid = (sent < 2000);
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (got != 2000 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_count: %0d results, %0d left outstanding, required 2000 and 0", got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
